// File: rtl/sram_arbiter_if.sv
// Bundle of the two requester ports and the SRAM controller command port
// handled by sram_arbiter.
interface sram_arbiter_if #(
  parameter int unsigned ADDR_W = 20,
  parameter int unsigned DATA_W = 8
);
  logic              req0;
  logic              rw0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              gnt0;
  logic              done0;
  logic [DATA_W-1:0] rdata0;

  logic              req1;
  logic              rw1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              gnt1;
  logic              done1;
  logic [DATA_W-1:0] rdata1;

  logic              mem;
  logic              rw;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data2ram;
  logic              ready;
  logic [DATA_W-1:0] data2fpga;
  logic              busy;
  logic              err;

  modport slave (
    input  req0, rw0, addr0, wdata0, req1, rw1, addr1, wdata1, ready, data2fpga,
    output gnt0, done0, rdata0, gnt1, done1, rdata1, mem, rw, addr, data2ram, busy, err
  );

  modport master (
    output req0, rw0, addr0, wdata0, req1, rw1, addr1, wdata1, ready, data2fpga,
    input  gnt0, done0, rdata0, gnt1, done1, rdata1, mem, rw, addr, data2ram, busy, err
  );
endinterface

// File: rtl/sram_arbiter.sv
// Two-port arbiter in front of a single SRAM controller: latches the winning
// command, strobes mem for one cycle and tracks the controller's ready handshake.
module sram_arbiter #(
  parameter int unsigned ADDR_W       = 20,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned FIXED_PRI    = 0,
  parameter int unsigned BUSY_TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  sram_arbiter_if.slave bus
);
  localparam int unsigned CntW       = $clog2(BUSY_TIMEOUT + 1);
  localparam bit          RoundRobin = (FIXED_PRI == 0);

  typedef enum logic [1:0] {StIdle, StWaitBusy, StWaitDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              last_q, last_d;
  logic              win_q, win_d;
  logic              mem_q, mem_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic              done0_q, done0_d, done1_q, done1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic              pick1;

  // Port 1 wins alone, or on contention when round-robin and port 0 was served last.
  assign pick1 = bus.req1 & (~bus.req0 | (RoundRobin & ~last_q));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    win_d    = win_q;
    mem_d    = 1'b0;
    rw_d     = rw_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    gnt0_d   = 1'b0;
    gnt1_d   = 1'b0;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    busy_d   = busy_q;
    err_d    = err_q;
    unique case (state_q)
      StIdle: begin
        if (bus.ready && (bus.req0 || bus.req1)) begin
          win_d   = pick1;
          rw_d    = pick1 ? bus.rw1 : bus.rw0;
          addr_d  = pick1 ? bus.addr1 : bus.addr0;
          wdata_d = pick1 ? bus.wdata1 : bus.wdata0;
          mem_d   = 1'b1;
          gnt0_d  = ~pick1;
          gnt1_d  = pick1;
          busy_d  = 1'b1;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = StWaitBusy;
        end
      end
      StWaitBusy: begin
        if (!bus.ready) begin
          state_d = StWaitDone;
        end else if (cnt_q >= CntW'(BUSY_TIMEOUT - 1)) begin
          // Controller never accepted the strobe: abort, rdata untouched.
          done0_d = ~win_q;
          done1_d = win_q;
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StWaitDone: begin
        if (bus.ready) begin
          done0_d = ~win_q;
          done1_d = win_q;
          if (rw_q && !win_q) rdata0_d = bus.data2fpga;
          if (rw_q && win_q)  rdata1_d = bus.data2fpga;
          busy_d  = 1'b0;
          last_d  = win_q;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      last_q   <= 1'b1;
      win_q    <= 1'b0;
      mem_q    <= 1'b0;
      rw_q     <= 1'b1;
      addr_q   <= '0;
      wdata_q  <= '0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      win_q    <= win_d;
      mem_q    <= mem_d;
      rw_q     <= rw_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
    end
  end

  assign bus.mem      = mem_q;
  assign bus.rw       = rw_q;
  assign bus.addr     = addr_q;
  assign bus.data2ram = wdata_q;
  assign bus.gnt0     = gnt0_q;
  assign bus.gnt1     = gnt1_q;
  assign bus.done0    = done0_q;
  assign bus.done1    = done1_q;
  assign bus.rdata0   = rdata0_q;
  assign bus.rdata1   = rdata1_q;
  assign bus.busy     = busy_q;
  assign bus.err      = err_q;
endmodule
